// File: rtl/qif_pkg.sv
// Types and constants shared by the QIF neuron and its downstream monitor.
// Both sides agree on the membrane voltage encoding.
package qif_pkg;
  localparam int V_W            = 8;
  localparam int THRESH_DEFAULT = 50;

  typedef logic signed [V_W-1:0] vmem_t;
endpackage

// File: rtl/isi_fifo.sv
// Small synchronous FIFO for inter-spike intervals; head is visible combinationally on dout.
// Writes while full are ignored unless a pop happens on the same edge.
module isi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic [DEPTH-1:0] wr_sel;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;
  assign dout  = mem_reg[rd_ptr_reg];

  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr_en && (wr_ptr_reg == AW'(gi));
  end

  always_comb begin
    count_next = count_reg;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) mem_reg[i] <= din;
      end
    end
  end
endmodule

// File: rtl/qif_spike_monitor.sv
// Spike detector for the QIF neuron: upward threshold crossings, inter-spike
// intervals into a FIFO, and a windowed firing-rate count.
module qif_spike_monitor
  import qif_pkg::*;
#(
  parameter int THRESH     = THRESH_DEFAULT,
  parameter int ISI_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int WIN_LEN    = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  vmem_t            v_mem,
  input  logic             clr_ovf,
  input  logic             isi_ready,
  output logic             spike,
  output logic [ISI_W-1:0] isi_data,
  output logic             isi_valid,
  output logic             overflow,
  output logic [7:0]       rate,
  output logic             rate_valid
);
  localparam int                 CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int                 WIN_W    = $clog2(WIN_LEN);
  localparam vmem_t              THRESH_V = vmem_t'(THRESH);
  localparam logic [ISI_W-1:0]   ISI_MAX  = {ISI_W{1'b1}};
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WIN_LEN - 1);

  vmem_t            v_q_reg;
  logic             spike_reg;
  logic             armed_reg;
  logic [ISI_W-1:0] isi_cnt_reg;
  logic [ISI_W-1:0] isi_cnt_next;
  logic             overflow_reg;
  logic [WIN_W-1:0] win_cnt_reg;
  logic [7:0]       win_spk_reg;
  logic [7:0]       win_spk_next;
  logic [7:0]       rate_reg;
  logic             rate_valid_reg;

  logic             hit;
  logic             push;
  logic             pop;
  logic             drop;
  logic [ISI_W-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;

  always_comb begin
    hit          = (v_mem >= THRESH_V) && !(v_q_reg >= THRESH_V);
    push         = hit && armed_reg;
    pop          = isi_valid && isi_ready;
    drop         = push && fifo_full && !pop;
    isi_cnt_next = hit ? ISI_W'(1)
                 : (isi_cnt_reg == ISI_MAX) ? isi_cnt_reg : isi_cnt_reg + ISI_W'(1);
    win_spk_next = (hit && win_spk_reg != 8'hFF) ? win_spk_reg + 8'd1 : win_spk_reg;
  end

  // The pre-edge counter value is the interval ending at this hit.
  isi_fifo #(
    .WIDTH (ISI_W),
    .DEPTH (FIFO_DEPTH)
  ) u_isi_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push && !drop),
    .din   (isi_cnt_reg),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign isi_valid  = (fifo_count != '0);
  assign isi_data   = fifo_empty ? '0 : fifo_dout;
  assign spike      = spike_reg;
  assign overflow   = overflow_reg;
  assign rate       = rate_reg;
  assign rate_valid = rate_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q_reg        <= '0;
      spike_reg      <= 1'b0;
      armed_reg      <= 1'b0;
      isi_cnt_reg    <= '0;
      overflow_reg   <= 1'b0;
      win_cnt_reg    <= '0;
      win_spk_reg    <= '0;
      rate_reg       <= '0;
      rate_valid_reg <= 1'b0;
    end else begin
      v_q_reg     <= v_mem;
      spike_reg   <= hit;
      armed_reg   <= armed_reg | hit;
      isi_cnt_reg <= isi_cnt_next;

      // A drop on the clearing edge keeps the flag set.
      if (drop)         overflow_reg <= 1'b1;
      else if (clr_ovf) overflow_reg <= 1'b0;

      if (win_cnt_reg == WIN_LAST) begin
        win_cnt_reg    <= '0;
        win_spk_reg    <= '0;
        rate_reg       <= win_spk_next;
        rate_valid_reg <= 1'b1;
      end else begin
        win_cnt_reg    <= win_cnt_reg + WIN_W'(1);
        win_spk_reg    <= win_spk_next;
        rate_valid_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_qif_spike_monitor.sv
// Directed bench for qif_spike_monitor: crossings, ISI capture, FIFO overflow,
// simultaneous push/pop at full, rate windows and mid-window reset.
module tb_qif_spike_monitor;
  import qif_pkg::*;

  localparam vmem_t V_HI = 8'sd60;
  localparam vmem_t V_LO = 8'sd0;

  logic       clk;
  logic       rst_n;
  vmem_t      v_mem;
  logic       clr_ovf;
  logic       isi_ready;
  logic       spike;
  logic [7:0] isi_data;
  logic       isi_valid;
  logic       overflow;
  logic [7:0] rate;
  logic       rate_valid;

  int total = 0;
  int bad   = 0;

  qif_spike_monitor #(
    .THRESH     (50),
    .ISI_W      (8),
    .FIFO_DEPTH (4),
    .WIN_LEN    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .v_mem      (v_mem),
    .clr_ovf    (clr_ovf),
    .isi_ready  (isi_ready),
    .spike      (spike),
    .isi_data   (isi_data),
    .isi_valid  (isi_valid),
    .overflow   (overflow),
    .rate       (rate),
    .rate_valid (rate_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; v_mem = V_LO; clr_ovf = 1'b0; isi_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // gap-1 low edges then one hit edge; isi_ready applied only on the hit edge.
  task automatic hit_after(input int gap, input logic rdy);
    isi_ready = 1'b0; v_mem = V_LO;
    repeat (gap - 1) tick();
    v_mem = V_HI; isi_ready = rdy;
    tick();
    isi_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v_mem = V_LO; clr_ovf = 1'b0; isi_ready = 1'b0;
    tick(); tick();
    total++;
    if ({spike, isi_valid, overflow, rate_valid} !== 4'b0 || isi_data !== 8'd0 || rate !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: got spike=%0b valid=%0b ovf=%0b rv=%0b data=%0d rate=%0d want all 0",
               spike, isi_valid, overflow, rate_valid, isi_data, rate);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (spike !== 1'b0 || isi_valid !== 1'b0 || overflow !== 1'b0 || rate !== 8'd0) begin
        bad++;
        $display("FAIL idle_cycle%0d: got spike=%0b valid=%0b ovf=%0b rate=%0d want 0 0 0 0",
                 i, spike, isi_valid, overflow, rate);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_crossing();
    vmem_t seq [6] = '{8'sd49, 8'sd50, 8'sd50, 8'sd50, -8'sd20, -8'sd20};
    logic  exp_spk [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      v_mem = seq[i];
      tick();
      total++;
      if (spike !== exp_spk[i] || isi_valid !== 1'b0) begin
        bad++;
        $display("FAIL single_step%0d: got spike=%0b valid=%0b want spike=%0b valid=0",
                 i, spike, isi_valid, exp_spk[i]);
      end
    end
    $display("test_single_crossing done");
  endtask

  task automatic test_isi_measure();
    apply_reset();
    isi_ready = 1'b1;
    v_mem = V_LO; tick();
    v_mem = V_HI; tick();
    total++;
    if (spike !== 1'b1 || isi_valid !== 1'b0) begin
      bad++;
      $display("FAIL isi_first_hit: got spike=%0b valid=%0b want 1 0", spike, isi_valid);
    end
    v_mem = V_LO;
    repeat (6) tick();
    v_mem = V_HI; tick();
    total++;
    if (spike !== 1'b1 || isi_valid !== 1'b1 || isi_data !== 8'd7) begin
      bad++;
      $display("FAIL isi_gap7: got spike=%0b valid=%0b data=%0d want 1 1 7", spike, isi_valid, isi_data);
    end
    v_mem = V_LO; tick();
    total++;
    if (isi_valid !== 1'b0 || isi_data !== 8'd0) begin
      bad++;
      $display("FAIL isi_popped: got valid=%0b data=%0d want 0 0", isi_valid, isi_data);
    end
    repeat (298) tick();
    v_mem = V_HI; tick();
    total++;
    if (isi_valid !== 1'b1 || isi_data !== 8'd255) begin
      bad++;
      $display("FAIL isi_saturate: got valid=%0b data=%0d want 1 255", isi_valid, isi_data);
    end
    v_mem = V_LO; tick();
    isi_ready = 1'b0;
    $display("test_isi_measure done");
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] exp_q [4] = '{8'd3, 8'd4, 8'd5, 8'd6};
    apply_reset();
    v_mem = V_LO; tick();
    v_mem = V_HI; tick();
    for (int g = 3; g <= 6; g++) hit_after(g, 1'b0);
    total++;
    if (overflow !== 1'b0 || isi_data !== 8'd3) begin
      bad++;
      $display("FAIL ovf_filled: got ovf=%0b head=%0d want 0 3", overflow, isi_data);
    end
    hit_after(7, 1'b0);
    total++;
    if (overflow !== 1'b1 || isi_valid !== 1'b1 || isi_data !== 8'd3) begin
      bad++;
      $display("FAIL ovf_drop: got ovf=%0b valid=%0b head=%0d want 1 1 3", overflow, isi_valid, isi_data);
    end
    v_mem = V_LO; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got ovf=%0b want 0", overflow);
    end
    v_mem = V_HI; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_clear_vs_drop: got ovf=%0b want 1", overflow);
    end
    v_mem = V_LO;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (isi_valid !== 1'b1 || isi_data !== exp_q[i]) begin
        bad++;
        $display("FAIL ovf_drain%0d: got valid=%0b data=%0d want 1 %0d", i, isi_valid, isi_data, exp_q[i]);
      end
      isi_ready = 1'b1; tick();
    end
    isi_ready = 1'b0;
    total++;
    if (isi_valid !== 1'b0 || isi_data !== 8'd0) begin
      bad++;
      $display("FAIL ovf_drained: got valid=%0b data=%0d want 0 0", isi_valid, isi_data);
    end
    $display("test_fifo_overflow done");
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q [4] = '{8'd3, 8'd4, 8'd5, 8'd6};
    apply_reset();
    v_mem = V_LO; tick();
    v_mem = V_HI; tick();
    for (int g = 2; g <= 5; g++) hit_after(g, 1'b0);
    total++;
    if (isi_data !== 8'd2 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL pp_filled: got head=%0d ovf=%0b want 2 0", isi_data, overflow);
    end
    hit_after(6, 1'b1);
    total++;
    if (overflow !== 1'b0 || isi_valid !== 1'b1 || isi_data !== 8'd3) begin
      bad++;
      $display("FAIL pp_at_full: got ovf=%0b valid=%0b head=%0d want 0 1 3", overflow, isi_valid, isi_data);
    end
    v_mem = V_LO;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (isi_valid !== 1'b1 || isi_data !== exp_q[i]) begin
        bad++;
        $display("FAIL pp_drain%0d: got valid=%0b data=%0d want 1 %0d", i, isi_valid, isi_data, exp_q[i]);
      end
      isi_ready = 1'b1; tick();
    end
    isi_ready = 1'b0;
    total++;
    if (isi_valid !== 1'b0) begin
      bad++;
      $display("FAIL pp_drained: got valid=%0b want 0", isi_valid);
    end
    $display("test_push_pop_full done");
  endtask

  task automatic test_rate();
    apply_reset();
    for (int e = 0; e <= 52; e++) begin
      v_mem = (e == 2 || e == 8 || e == 15 || e == 34 || e == 37 || e == 50) ? V_HI : V_LO;
      isi_ready = (e < 33);
      tick();
      case (e)
        14: begin
          total++;
          if (rate_valid !== 1'b0 || rate !== 8'd0) begin
            bad++;
            $display("FAIL rate_pre_w0: got rv=%0b rate=%0d want 0 0", rate_valid, rate);
          end
        end
        15: begin
          total++;
          if (rate_valid !== 1'b1 || rate !== 8'd3) begin
            bad++;
            $display("FAIL rate_w0: got rv=%0b rate=%0d want 1 3", rate_valid, rate);
          end
        end
        16: begin
          total++;
          if (rate_valid !== 1'b0 || rate !== 8'd3) begin
            bad++;
            $display("FAIL rate_w0_hold: got rv=%0b rate=%0d want 0 3", rate_valid, rate);
          end
        end
        31: begin
          total++;
          if (rate_valid !== 1'b1 || rate !== 8'd0) begin
            bad++;
            $display("FAIL rate_w1: got rv=%0b rate=%0d want 1 0", rate_valid, rate);
          end
        end
        47: begin
          total++;
          if (rate_valid !== 1'b1 || rate !== 8'd2) begin
            bad++;
            $display("FAIL rate_w2: got rv=%0b rate=%0d want 1 2", rate_valid, rate);
          end
        end
        52: begin
          total++;
          if (isi_valid !== 1'b1 || isi_data !== 8'd19 || rate !== 8'd2) begin
            bad++;
            $display("FAIL rate_pre_rst: got valid=%0b data=%0d rate=%0d want 1 19 2", isi_valid, isi_data, rate);
          end
        end
        default: ;
      endcase
    end
    isi_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (rate !== 8'd0 || isi_valid !== 1'b0 || isi_data !== 8'd0 || rate_valid !== 1'b0) begin
      bad++;
      $display("FAIL rate_async_rst: got rate=%0d valid=%0b data=%0d rv=%0b want 0 0 0 0",
               rate, isi_valid, isi_data, rate_valid);
    end
    tick();
    rst_n = 1'b1;
    $display("test_rate done");
  endtask

  initial begin
    rst_n = 1'b0; v_mem = V_LO; clr_ovf = 1'b0; isi_ready = 1'b0;
    test_reset();
    test_single_crossing();
    test_isi_measure();
    test_fifo_overflow();
    test_push_pop_full();
    test_rate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qif_spike_monitor.md
Name: qif_spike_monitor

Overview:
Downstream stage of the 8-bit QIF neuron. Samples the signed membrane voltage every clock and detects spikes as upward threshold crossings. For each spike it emits a one-cycle pulse and measures the inter-spike interval (ISI). ISIs are buffered in a small FIFO with a valid/ready output, and a windowed spike count (firing rate) is published periodically.

Parameters:
THRESH, 50, signed spike threshold compared against v_mem
ISI_W, 8, ISI counter/data width; counter saturates at 2^ISI_W-1
FIFO_DEPTH, 4, ISI FIFO entries (power of two, >=2)
WIN_LEN, 256, rate window length in clock cycles (>=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
v_mem  in  8  signed membrane voltage from the neuron
clr_ovf  in  1  clears the overflow flag
isi_ready  in  1  consumer accepts isi_data this cycle
spike  out  1  one-cycle pulse per detected spike
isi_data  out  ISI_W  FIFO head: cycles between consecutive spikes
isi_valid  out  1  FIFO non-empty
overflow  out  1  sticky: an ISI was dropped because the FIFO was full
rate  out  8  spike count of the last completed window, saturating at 255
rate_valid  out  1  one-cycle pulse when rate updates

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0: spike=0, isi_valid=0, isi_data=0, overflow=0, rate=0, rate_valid=0, FIFO empty, armed=0, ISI counter=0, window counter=0, window spike count=0, previous-sample register v_q=0. Reset mid-operation discards all buffered ISIs and any partial window.
- Detection: hit = ($signed(v_mem) >= THRESH) && !($signed(v_q) >= THRESH). v_q <= v_mem every edge. spike is registered: it is high for exactly the cycle after the edge that sampled hit=1. A level held at or above THRESH yields one spike only.
- First sample after reset: v_q=0, so v_mem>=THRESH on that edge counts as a spike.
- ISI counter: on a hit edge it loads 1; otherwise it increments, saturating at 2^ISI_W-1. On a hit edge with armed=1, the pre-edge counter value is pushed. This equals the number of edges between the two hit edges, saturated. The first hit after reset sets armed=1 and pushes nothing.
- FIFO: push = hit && armed; pop = isi_valid && isi_ready. isi_data = head when isi_valid=1, else 0. A push into an empty FIFO makes isi_valid high the cycle after the edge. Push while full and no pop: the new value is dropped, the contents are unchanged, and overflow is set. Push while full with pop: both take effect with no drop. Push and pop on a one-entry FIFO: it stays non-empty and the head becomes the new value. Pointers wrap modulo FIFO_DEPTH, and an occupancy counter disambiguates full from empty.
- overflow is sticky. A clr_ovf edge clears it, but a drop on the same edge wins and leaves it set.
- Rate window: the window counter runs 0..WIN_LEN-1 and wraps. The window spike count increments on each hit edge, saturating at 255. On the edge where the window counter = WIN_LEN-1: rate <= count plus that edge's hit (saturating), rate_valid pulses for the following cycle, and the count restarts at 0. The first window starts at the first edge after reset release.
- Output latencies, all one cycle from the sampling edge: spike, FIFO push, rate update.

Decomposition:
- Shared package qif_pkg: V_W=8, THRESH_DEFAULT=50, typedef logic signed [V_W-1:0] vmem_t. The neuron and this block share these.
- Sub-module isi_fifo: a synchronous FIFO with parameters WIDTH and DEPTH; ports push, din, pop, dout, empty, full, count. Full-drop policy and overflow flag stay in qif_spike_monitor.

Test Plan:
- Reset/idle: hold v_mem=0 for 20 cycles after release -> spike=0, isi_valid=0, overflow=0, rate=0.
- Single crossing: v_mem=49 then 50 held 3 cycles -> exactly one spike pulse, no FIFO push (first spike, unarmed); v_mem=-20 returns no extra pulse.
- ISI measure: hits at edges k and k+7, isi_ready=1 -> isi_valid high one cycle with isi_data=7; a gap of 300 with ISI_W=8 -> isi_data=255.
- FIFO full/overflow: isi_ready=0, six hits (five ISIs, gaps 3,4,5,6,7) -> FIFO holds 3,4,5,6; overflow=1; drain gives 3,4,5,6 then isi_valid=0. clr_ovf clears the flag; clr_ovf concurrent with a drop keeps it set.
- Simultaneous push/pop at full: FIFO full, isi_ready=1 on a hit edge -> no overflow, and the new ISI appears as the last entry.
- Rate: WIN_LEN=16, three spikes in the first window, including one on the final edge -> rate=3 with a one-cycle rate_valid; the next window with 0 spikes -> rate=0. Asserting rst_n=0 mid-window clears rate and the FIFO immediately.
